// File: rtl/imem_dmem_arb.sv
// -----------------------------------------------------------------------------
// imem_dmem_arb
//   Shares one single-ported memory bus between the fetch stage (instruction
//   reads) and the mem stage (data loads/stores). Only one bus transaction is
//   outstanding at a time. The mem stage normally wins, but after
//   MAX_MEM_WINS consecutive mem grants while fetch is waiting, fetch wins
//   once so it always makes forward progress. A fetch response whose address
//   no longer matches the live fetch request is dropped.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   ftch_imem_vld/addr              fetch read request (held or withdrawn)
//   imem_ftch_vld/data              fetch response, one-cycle pulse
//   mem_dmem_vld/we/addr/wdata/be   data request (held until response)
//   dmem_mem_vld/rdata              data response / store ack, one-cycle
//   arb_bus_vld/we/addr/wdata/be    bus request to the memory model
//   arb_bus_rdy                     bus accepts request when vld & rdy
//   bus_arb_vld/rdata               bus response, >=1 cycle after accept
// -----------------------------------------------------------------------------
module imem_dmem_arb #(
  parameter int MAX_MEM_WINS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ftch_imem_vld,
  input  logic [31:0] ftch_imem_addr,
  output logic        imem_ftch_vld,
  output logic [31:0] imem_ftch_data,
  input  logic        mem_dmem_vld,
  input  logic        mem_dmem_we,
  input  logic [31:0] mem_dmem_addr,
  input  logic [31:0] mem_dmem_wdata,
  input  logic [3:0]  mem_dmem_be,
  output logic        dmem_mem_vld,
  output logic [31:0] dmem_mem_rdata,
  output logic        arb_bus_vld,
  input  logic        arb_bus_rdy,
  output logic        arb_bus_we,
  output logic [31:0] arb_bus_addr,
  output logic [31:0] arb_bus_wdata,
  output logic [3:0]  arb_bus_be,
  input  logic        bus_arb_vld,
  input  logic [31:0] bus_arb_rdata
);

  localparam int CW = $clog2(MAX_MEM_WINS + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_MEM_WINS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_e;

  typedef enum logic {
    OWN_FTCH,
    OWN_MEM
  } owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [31:0]   tag_q, tag_d;
  logic [31:0]   faddr_q, faddr_d;

  owner_e        cur_owner;
  logic          req_vld;
  logic          accept;
  logic          pick_mem;
  logic [31:0]   issue_addr;
  logic          ftch_rsp;
  logic          mem_rsp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_FTCH;
      starve_q <= '0;
      tag_q    <= '0;
      faddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      tag_q    <= tag_d;
      faddr_q  <= faddr_d;
    end
  end

  // Mem wins unless fetch has already been passed over MAX_MEM_WINS times.
  assign pick_mem = mem_dmem_vld && !((starve_q == STARVE_MAX) && ftch_imem_vld);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    tag_d      = tag_q;
    faddr_d    = faddr_q;
    cur_owner  = owner_q;
    req_vld    = 1'b0;
    issue_addr = faddr_q;
    ftch_rsp   = 1'b0;
    mem_rsp    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Arbitrate and drive the bus in the same cycle; the fetch address
        // is captured here so a later change cannot alter a pending request.
        if (ftch_imem_vld || mem_dmem_vld) begin
          req_vld    = 1'b1;
          cur_owner  = pick_mem ? OWN_MEM : OWN_FTCH;
          owner_d    = cur_owner;
          faddr_d    = ftch_imem_addr;
          issue_addr = ftch_imem_addr;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // Grant is sticky; a withdrawn fetch still completes on the bus.
        req_vld = 1'b1;
      end
      ST_WAIT: begin
        if (bus_arb_vld) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_MEM) begin
            mem_rsp = 1'b1;
          end else begin
            ftch_rsp = ftch_imem_vld && (ftch_imem_addr == tag_q);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (cur_owner == OWN_MEM) begin
      issue_addr = mem_dmem_addr;
    end

    accept = req_vld && arb_bus_rdy;
    if (accept) begin
      tag_d   = issue_addr;
      state_d = ST_WAIT;
    end

    if (!ftch_imem_vld) begin
      starve_d = '0;
    end else if (accept) begin
      if (cur_owner == OWN_FTCH) begin
        starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
        starve_d = starve_q + CW'(1);
      end
    end
  end

  // Outputs are forced low while reset is asserted, even mid-transaction.
  always_comb begin
    arb_bus_vld    = 1'b0;
    arb_bus_we     = 1'b0;
    arb_bus_addr   = '0;
    arb_bus_wdata  = '0;
    arb_bus_be     = '0;
    imem_ftch_vld  = 1'b0;
    imem_ftch_data = '0;
    dmem_mem_vld   = 1'b0;
    dmem_mem_rdata = '0;
    if (!reset) begin
      if (req_vld) begin
        arb_bus_vld  = 1'b1;
        arb_bus_addr = issue_addr;
        if (cur_owner == OWN_MEM) begin
          arb_bus_we    = mem_dmem_we;
          arb_bus_wdata = mem_dmem_wdata;
          arb_bus_be    = mem_dmem_be;
        end
      end
      if (ftch_rsp) begin
        imem_ftch_vld  = 1'b1;
        imem_ftch_data = bus_arb_rdata;
      end
      if (mem_rsp) begin
        dmem_mem_vld   = 1'b1;
        dmem_mem_rdata = bus_arb_rdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_arb.sv
// -----------------------------------------------------------------------------
// tb_imem_dmem_arb
//   Directed bench for imem_dmem_arb. A simple bus memory model answers each
//   accepted request after rspLat cycles with data 0x2408000A ^ addr. Expected
//   bus issues and responses are queued by the stimulus; a monitor on the
//   falling edge pops and compares whenever the DUT issues or responds.
// -----------------------------------------------------------------------------
module tb_imem_dmem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        ftch_imem_vld;
  logic [31:0] ftch_imem_addr;
  logic        imem_ftch_vld;
  logic [31:0] imem_ftch_data;
  logic        mem_dmem_vld;
  logic        mem_dmem_we;
  logic [31:0] mem_dmem_addr;
  logic [31:0] mem_dmem_wdata;
  logic [3:0]  mem_dmem_be;
  logic        dmem_mem_vld;
  logic [31:0] dmem_mem_rdata;
  logic        arb_bus_vld;
  logic        arb_bus_rdy;
  logic        arb_bus_we;
  logic [31:0] arb_bus_addr;
  logic [31:0] arb_bus_wdata;
  logic [3:0]  arb_bus_be;
  logic        bus_arb_vld;
  logic [31:0] bus_arb_rdata;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } issue_t;

  typedef struct packed {
    logic        isMem;
    logic [31:0] data;
  } resp_t;

  issue_t expIssue[$];
  resp_t  expResp[$];

  int total = 0;
  int bad = 0;
  int acceptCount = 0;
  int ftchRespCount = 0;
  int memRespCount = 0;
  int rspLat = 2;
  bit acceptSeen = 1'b0;
  bit pending = 1'b0;
  int cnt = 0;
  logic [31:0] pendAddr = '0;

  imem_dmem_arb #(.MAX_MEM_WINS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ftch_imem_vld  (ftch_imem_vld),
    .ftch_imem_addr (ftch_imem_addr),
    .imem_ftch_vld  (imem_ftch_vld),
    .imem_ftch_data (imem_ftch_data),
    .mem_dmem_vld   (mem_dmem_vld),
    .mem_dmem_we    (mem_dmem_we),
    .mem_dmem_addr  (mem_dmem_addr),
    .mem_dmem_wdata (mem_dmem_wdata),
    .mem_dmem_be    (mem_dmem_be),
    .dmem_mem_vld   (dmem_mem_vld),
    .dmem_mem_rdata (dmem_mem_rdata),
    .arb_bus_vld    (arb_bus_vld),
    .arb_bus_rdy    (arb_bus_rdy),
    .arb_bus_we     (arb_bus_we),
    .arb_bus_addr   (arb_bus_addr),
    .arb_bus_wdata  (arb_bus_wdata),
    .arb_bus_be     (arb_bus_be),
    .bus_arb_vld    (bus_arb_vld),
    .bus_arb_rdata  (bus_arb_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return 32'h2408000A ^ a;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=event required=none", name);
  endtask

  task automatic applyStimulus(input logic fv, input logic [31:0] fa,
                               input logic mv, input logic mwe,
                               input logic [31:0] ma, input logic [31:0] mwd,
                               input logic [3:0] mbe);
    @(posedge clk);
    #1;
    ftch_imem_vld  = fv;
    ftch_imem_addr = fa;
    mem_dmem_vld   = mv;
    mem_dmem_we    = mwe;
    mem_dmem_addr  = ma;
    mem_dmem_wdata = mwd;
    mem_dmem_be    = mbe;
  endtask

  // Releases each requester once its response count reaches the target.
  task automatic waitResp(input int fTarget, input int mTarget);
    int i;
    for (i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (ftchRespCount >= fTarget) ftch_imem_vld = 1'b0;
      if (memRespCount >= mTarget) mem_dmem_vld = 1'b0;
      if (ftchRespCount >= fTarget && memRespCount >= mTarget) break;
    end
    if (i == 400) reportFail("resp_timeout");
  endtask

  task automatic waitAccept(input int target);
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (acceptCount >= target) break;
    end
    if (i == 200) reportFail("accept_timeout");
  endtask

  // Monitor: samples DUT outputs mid-cycle and checks against the queues.
  always @(negedge clk) begin
    issue_t ei;
    resp_t  er;
    if (arb_bus_vld && arb_bus_rdy) begin
      acceptSeen = 1'b1;
      pendAddr   = arb_bus_addr;
      acceptCount++;
      if (expIssue.size() == 0) begin
        reportFail("unexpected_issue");
      end else begin
        ei = expIssue.pop_front();
        checkOutput("issue_we", {31'b0, arb_bus_we}, {31'b0, ei.we});
        checkOutput("issue_addr", arb_bus_addr, ei.addr);
        checkOutput("issue_wdata", arb_bus_wdata, ei.wdata);
        checkOutput("issue_be", {28'b0, arb_bus_be}, {28'b0, ei.be});
      end
    end
    if (imem_ftch_vld && dmem_mem_vld) begin
      reportFail("both_resp");
    end else if (imem_ftch_vld || dmem_mem_vld) begin
      if (expResp.size() == 0) begin
        reportFail("unexpected_resp");
      end else begin
        er = expResp.pop_front();
        checkOutput("resp_kind", {31'b0, dmem_mem_vld}, {31'b0, er.isMem});
        checkOutput("resp_data", dmem_mem_vld ? dmem_mem_rdata : imem_ftch_data, er.data);
      end
      if (imem_ftch_vld) ftchRespCount++;
      if (dmem_mem_vld) memRespCount++;
    end
  end

  // Bus memory model: responds rspLat cycles after each accept.
  always @(posedge clk) begin
    #1;
    bus_arb_vld   = 1'b0;
    bus_arb_rdata = '0;
    if (acceptSeen) begin
      acceptSeen = 1'b0;
      pending    = 1'b1;
      cnt        = rspLat;
    end
    if (pending) begin
      cnt--;
      if (cnt == 0) begin
        bus_arb_vld   = 1'b1;
        bus_arb_rdata = memData(pendAddr);
        pending       = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int f0;
    int m0;
    int a0;
    reset          = 1'b1;
    ftch_imem_vld  = 1'b1;
    ftch_imem_addr = 32'h0;
    mem_dmem_vld   = 1'b1;
    mem_dmem_we    = 1'b0;
    mem_dmem_addr  = 32'h0;
    mem_dmem_wdata = 32'h0;
    mem_dmem_be    = 4'h0;
    arb_bus_rdy    = 1'b1;
    bus_arb_vld    = 1'b0;
    bus_arb_rdata  = '0;

    // Reset with requests pending: nothing may reach the bus.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_bus_vld", {31'b0, arb_bus_vld}, 32'h0);
    checkOutput("reset_imem_vld", {31'b0, imem_ftch_vld}, 32'h0);
    checkOutput("reset_dmem_vld", {31'b0, dmem_mem_vld}, 32'h0);
    @(posedge clk);
    #1;
    reset         = 1'b0;
    ftch_imem_vld = 1'b0;
    mem_dmem_vld  = 1'b0;
    @(negedge clk);
    checkOutput("idle_bus_vld", {31'b0, arb_bus_vld}, 32'h0);

    // Fetch only from address 0.
    $display("[TB] fetch only");
    f0 = ftchRespCount;
    m0 = memRespCount;
    expIssue.push_back('{1'b0, 32'h0, 32'h0, 4'h0});
    expResp.push_back('{1'b0, 32'h2408000A});
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitResp(f0 + 1, m0);
    @(negedge clk);
    checkOutput("after_fetch_bus_vld", {31'b0, arb_bus_vld}, 32'h0);
    checkOutput("after_fetch_imem_vld", {31'b0, imem_ftch_vld}, 32'h0);

    // Simultaneous requests: mem load first, then fetch.
    $display("[TB] simultaneous requests");
    f0 = ftchRespCount;
    m0 = memRespCount;
    expIssue.push_back('{1'b0, 32'h100, 32'h0, 4'h0});
    expIssue.push_back('{1'b0, 32'h4, 32'h0, 4'h0});
    expResp.push_back('{1'b1, 32'h2408010A});
    expResp.push_back('{1'b0, 32'h2408000E});
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    waitResp(f0 + 1, m0 + 1);

    // Both held: starvation limit gives M,M,M,M,F,M,M,M,M,F.
    $display("[TB] starvation limit");
    f0 = ftchRespCount;
    m0 = memRespCount;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        expIssue.push_back('{1'b0, 32'h300, 32'h0, 4'h0});
        expResp.push_back('{1'b1, 32'h2408030A});
      end
      expIssue.push_back('{1'b0, 32'h8, 32'h0, 4'h0});
      expResp.push_back('{1'b0, 32'h24080002});
    end
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    waitResp(f0 + 2, m0 + 8);

    // Fetch redirect while waiting: stale response dropped, new addr issued.
    $display("[TB] fetch redirect");
    rspLat = 3;
    f0 = ftchRespCount;
    a0 = acceptCount;
    expIssue.push_back('{1'b0, 32'h8, 32'h0, 4'h0});
    expIssue.push_back('{1'b0, 32'h40, 32'h0, 4'h0});
    expResp.push_back('{1'b0, 32'h2408004A});
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitAccept(a0 + 1);
    ftch_imem_addr = 32'h40;
    waitResp(f0 + 1, memRespCount);

    // Store stalled by rdy: bus fields must hold steady.
    $display("[TB] stalled store");
    rspLat = 2;
    m0 = memRespCount;
    expIssue.push_back('{1'b1, 32'h200, 32'hDEADBEEF, 4'b0011});
    expResp.push_back('{1'b1, 32'h2408020A});
    @(posedge clk);
    #1;
    arb_bus_rdy = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'b0011);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_bus_vld", {31'b0, arb_bus_vld}, 32'h1);
      checkOutput("stall_bus_we", {31'b0, arb_bus_we}, 32'h1);
      checkOutput("stall_bus_addr", arb_bus_addr, 32'h200);
      checkOutput("stall_bus_wdata", arb_bus_wdata, 32'hDEADBEEF);
      checkOutput("stall_bus_be", {28'b0, arb_bus_be}, 32'h3);
    end
    @(posedge clk);
    #1;
    arb_bus_rdy = 1'b1;
    waitResp(ftchRespCount, m0 + 1);

    // Reset during WAIT: later stray response must be ignored.
    $display("[TB] reset in wait");
    rspLat = 4;
    a0 = acceptCount;
    expIssue.push_back('{1'b0, 32'hC, 32'h0, 4'h0});
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitAccept(a0 + 1);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("rst_wait_bus_vld", {31'b0, arb_bus_vld}, 32'h0);
      checkOutput("rst_wait_imem_vld", {31'b0, imem_ftch_vld}, 32'h0);
      if (k == 0) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    reset         = 1'b0;
    ftch_imem_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stray_imem_vld", {31'b0, imem_ftch_vld}, 32'h0);
      checkOutput("stray_dmem_vld", {31'b0, dmem_mem_vld}, 32'h0);
      checkOutput("stray_bus_vld", {31'b0, arb_bus_vld}, 32'h0);
    end

    repeat (4) @(posedge clk);
    checkOutput("issue_queue_empty", expIssue.size(), 32'h0);
    checkOutput("resp_queue_empty", expResp.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
